decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 48 ++++
 rtl/decode_fields.sv | 52 +++++
 rtl/decode_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, op-class enum and decoded-word type
// for the decode stage. Field widths here match the decode_stage parameter
// defaults (REG_AW=5, IMM_W=16).
package decode_pkg;

    localparam int unsigned OPC_W      = 6;
    localparam int unsigned DEC_REG_AW = 5;
    localparam int unsigned DEC_IMM_W  = 16;

    localparam logic [OPC_W-1:0] OPC_LDI    = 6'h00;
    localparam logic [OPC_W-1:0] OPC_MOV    = 6'h01;
    localparam logic [OPC_W-1:0] OPC_ALU_LO = 6'h04;
    localparam logic [OPC_W-1:0] OPC_ALU_HI = 6'h10;

    typedef enum logic [1:0] {
        CLS_LDI,
        CLS_MOV,
        CLS_ALU,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic [DEC_REG_AW-1:0] rdst2;
        logic [DEC_REG_AW-1:0] rdst1;
        logic [DEC_REG_AW-1:0] rsrc2;
        logic [DEC_REG_AW-1:0] rsrc1;
        logic [DEC_IMM_W-1:0]  imm;
        logic                  we2;
        logic                  we1;
        logic                  use2;
        logic                  use1;
        logic                  illegal;
    } dec_word_t;

    // Map an opcode onto its class; anything unmapped is illegal.
    function automatic op_class_e op_class(input logic [OPC_W-1:0] opc);
        if (opc == OPC_LDI) begin
            return CLS_LDI;
        end else if (opc == OPC_MOV) begin
            return CLS_MOV;
        end else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) begin
            return CLS_ALU;
        end
        return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// decode_fields: purely combinational instruction-word to decoded-word map.
// Ports:
//   code - instruction word (opcode in the top 6 bits)
//   word - decoded fields and enables; fields unused by the class read 0
module decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned IMM_W   = 16
) (
    input  logic [INSTR_W-1:0] code,
    output dec_word_t          word
);

    op_class_e cls;

    assign cls = op_class(code[INSTR_W-1 -: OPC_W]);

    // Start from all-zero so every field a class does not use reads 0.
    always_comb begin
        word        = '0;
        word.opcode = code[INSTR_W-1 -: OPC_W];
        case (cls)
            CLS_LDI: begin
                word.rdst2 = code[INSTR_W-7 -: REG_AW];
                word.imm   = code[IMM_W-1:0];
                word.we2   = 1'b1;
            end
            CLS_MOV: begin
                word.rdst2 = code[INSTR_W-7 -: REG_AW];
                word.rsrc2 = code[2*REG_AW-1:REG_AW];
                word.we2   = 1'b1;
                word.use2  = 1'b1;
            end
            CLS_ALU: begin
                word.rdst2 = code[INSTR_W-7 -: REG_AW];
                word.rdst1 = code[INSTR_W-7-REG_AW -: REG_AW];
                word.rsrc2 = code[2*REG_AW-1:REG_AW];
                word.rsrc1 = code[REG_AW-1:0];
                word.we2   = 1'b1;
                word.we1   = 1'b1;
                word.use2  = 1'b1;
                word.use1  = 1'b1;
            end
            default: begin
                word.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-deep registered decode stage with valid/ready handshake.
// Optional register scoreboard enabled by defining DECODE_SCOREBOARD_EN.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - kill the held word, block acceptance this cycle
//   in_valid/in_ready   - upstream handshake, in_code instruction word
//   out_valid/out_ready - downstream handshake for the decoded word
//   rdst2..illegal      - registered decoded fields and enables
//   wb_valid, wb_reg0/1 - writeback strobes clearing scoreboard bits
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned NUM_REGS = 2**REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_AW-1:0]  rdst2,
    output logic [REG_AW-1:0]  rdst1,
    output logic [REG_AW-1:0]  rsrc2,
    output logic [REG_AW-1:0]  rsrc1,
    output logic [IMM_W-1:0]   imm,
    output logic [5:0]         opcode,
    output logic               we2,
    output logic               we1,
    output logic               use2,
    output logic               use1,
    output logic               illegal,
    input  logic [1:0]         wb_valid,
    input  logic [REG_AW-1:0]  wb_reg0,
    input  logic [REG_AW-1:0]  wb_reg1
);

    dec_word_t dec;
    dec_word_t word_q, word_d;
    logic      out_valid_q, out_valid_d;
    logic      hazard;
    logic      accept;

    decode_fields #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .IMM_W   (IMM_W)
    ) u_fields (
        .code (in_code),
        .word (dec)
    );

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready && !flush;

    // Output register: flush wins, then a new word, then drain to empty.
    always_comb begin
        out_valid_d = out_valid_q;
        word_d      = word_q;
        if (flush) begin
            out_valid_d = 1'b0;
            word_d      = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            word_d      = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            word_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] pend;
    logic                issue;

    assign issue = out_valid_q && out_ready;

    // Dests of the held word count as busy so a dependant cannot slip past it.
    always_comb begin
        pend = busy_q;
        if (out_valid_q && word_q.we1) pend[word_q.rdst1] = 1'b1;
        if (out_valid_q && word_q.we2) pend[word_q.rdst2] = 1'b1;
        hazard = (dec.use1 && pend[dec.rsrc1]) ||
                 (dec.use2 && pend[dec.rsrc2]) ||
                 (dec.we1  && pend[dec.rdst1]) ||
                 (dec.we2  && pend[dec.rdst2]);
    end

    // Clears applied first so a same-cycle issue set overrides them.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid[0]) busy_d[wb_reg0] = 1'b0;
        if (wb_valid[1]) busy_d[wb_reg1] = 1'b0;
        if (issue && word_q.we1) busy_d[word_q.rdst1] = 1'b1;
        if (issue && word_q.we2) busy_d[word_q.rdst2] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = (^{wb_valid, wb_reg0, wb_reg1}) ^ (NUM_REGS == 0);
`endif

    assign out_valid = out_valid_q;
    assign opcode    = word_q.opcode;
    assign rdst2     = word_q.rdst2;
    assign rdst1     = word_q.rdst1;
    assign rsrc2     = word_q.rsrc2;
    assign rsrc1     = word_q.rsrc1;
    assign imm       = word_q.imm;
    assign we2       = word_q.we2;
    assign we1       = word_q.we1;
    assign use2      = word_q.use2;
    assign use1      = word_q.use1;
    assign illegal   = word_q.illegal;

endmodule
